condunit_mt: RTL and testbench

- Parametrised, multi-threaded conditional-execution and flag unit for the E stage of the ARM-style pipeline.
- Holds an architectural NZCV register per hardware thread.
- Holds a Thumb-style IT-block state register per thread and sequences it.
- Evaluates the effective condition of each E-stage instruction, gates its write controls, and updates flags and IT state on accepted instructions.
- Provides a flag/IT read port for the D stage.

---
 rtl/condunit_mt.sv | 168 ++++++++++++++++
 tb/tb_condunit_mt.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/condunit_mt.sv
// Multi-threaded conditional-execution and flag unit for the E stage.
// Holds per-thread NZCV flags and IT-block state, gates write controls, and bypasses updates to D.
module condunit_mt #(
    parameter int unsigned NTHREADS = 2,
    parameter int unsigned TIDW     = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidE,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [TIDW-1:0] TidE,
    input  logic [3:0]      CondE,
    input  logic [1:0]      FlagWriteE,
    input  logic [3:0]      ALUFlags,
    input  logic            RegWrite,
    input  logic            MemWrite,
    input  logic            PCSrc,
    input  logic            BranchE,
    input  logic            ITE,
    input  logic [3:0]      ITFirstCondE,
    input  logic [3:0]      ITMaskE,
    input  logic [TIDW-1:0] TidD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            PCSrcE,
    output logic            BranchTakenE,
    output logic            CondExE,
    output logic            UndefE,
    output logic [3:0]      FlagsE,
    output logic [3:0]      FlagsD,
    output logic            ITActiveD
);

    localparam int unsigned FLAGW = 4;
    localparam int unsigned ITW   = 8;

    logic [FLAGW-1:0] flags_q [NTHREADS];
    logic [FLAGW-1:0] flags_d [NTHREADS];
    logic [ITW-1:0]   it_q    [NTHREADS];
    logic [ITW-1:0]   it_d    [NTHREADS];

    logic [TIDW-1:0]  tid_e;
    logic [TIDW-1:0]  tid_d;
    logic [FLAGW-1:0] cur_flags;
    logic [ITW-1:0]   cur_it;
    logic [FLAGW-1:0] rd_flags;
    logic [ITW-1:0]   rd_it;
    logic [FLAGW-1:0] new_flags;
    logic [ITW-1:0]   new_it;
    logic [3:0]       eff_cond;
    logic             it_active;
    logic             accept;
    logic             cond_ex;

    // Condition-code evaluation over {N,Z,C,V}; 4'b1111 never passes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, g;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        g  = (n == v);
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = ~cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cf & ~z;
            4'b1001: cond_pass = ~(cf & ~z);
            4'b1010: cond_pass = g;
            4'b1011: cond_pass = ~g;
            4'b1100: cond_pass = ~z & g;
            4'b1101: cond_pass = ~(~z & g);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Thread selection and per-thread reads; a single thread ignores the id ports.
    always_comb begin
        tid_e     = (NTHREADS == 1) ? '0 : TidE;
        tid_d     = (NTHREADS == 1) ? '0 : TidD;
        cur_flags = '0;
        cur_it    = '0;
        rd_flags  = '0;
        rd_it     = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (TIDW'(t) == tid_e) begin
                cur_flags = flags_q[t];
                cur_it    = it_q[t];
            end
            if (TIDW'(t) == tid_d) begin
                rd_flags = flags_q[t];
                rd_it    = it_q[t];
            end
        end
    end

    // Effective condition, gating and post-update values for the E-stage thread.
    always_comb begin
        accept    = ValidE & ~StallE & ~FlushE & ~reset;
        it_active = (cur_it[3:0] != 4'b0000);
        eff_cond  = (it_active && !ITE) ? cur_it[7:4] : CondE;
        cond_ex   = cond_pass(eff_cond, cur_flags);

        CondExE      = cond_ex & accept;
        UndefE       = (eff_cond == 4'b1111) & accept;
        RegWriteE    = RegWrite & CondExE;
        MemWriteE    = MemWrite & CondExE;
        PCSrcE       = PCSrc & CondExE;
        BranchTakenE = BranchE & CondExE;

        new_flags = cur_flags;
        if (accept && cond_ex) begin
            if (FlagWriteE[1]) new_flags[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) new_flags[1:0] = ALUFlags[1:0];
        end

        new_it = cur_it;
        if (accept) begin
            if (ITE) begin
                if (cond_ex && (ITMaskE != 4'b0000)) new_it = {ITFirstCondE, ITMaskE};
            end else if (it_active) begin
                if (cur_it[2:0] == 3'b000) new_it = '0;
                else                       new_it = {cur_it[7:5], cur_it[3:0], 1'b0};
            end
        end
    end

    // Next-state arrays: only the accepted thread changes.
    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            flags_d[t] = flags_q[t];
            it_d[t]    = it_q[t];
            if (reset) begin
                flags_d[t] = '0;
                it_d[t]    = '0;
            end else if (accept && (TIDW'(t) == tid_e)) begin
                flags_d[t] = new_flags;
                it_d[t]    = new_it;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < NTHREADS; t++) begin
            flags_q[t] <= flags_d[t];
            it_q[t]    <= it_d[t];
        end
    end

    // D-stage read port with same-cycle bypass of the value being written.
    always_comb begin
        FlagsE    = cur_flags;
        FlagsD    = rd_flags;
        ITActiveD = (rd_it[3:0] != 4'b0000);
        if (accept && (tid_d == tid_e)) begin
            FlagsD    = new_flags;
            ITActiveD = (new_it[3:0] != 4'b0000);
        end
    end

endmodule

// File: tb/tb_condunit_mt.sv
// Directed self-checking bench for condunit_mt with hand-computed expectations.
module tb_condunit_mt;

    localparam int unsigned NT = 2;
    localparam int unsigned TW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ValidE, StallE, FlushE;
    logic [TW-1:0] TidE, TidD;
    logic [3:0]    CondE, ALUFlags, ITFirstCondE, ITMaskE;
    logic [1:0]    FlagWriteE;
    logic          RegWrite, MemWrite, PCSrc, BranchE, ITE;
    logic          RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE, UndefE, ITActiveD;
    logic [3:0]    FlagsE, FlagsD;

    int n_checks = 0;
    int n_errors = 0;

    condunit_mt #(.NTHREADS(NT)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .TidE(TidE), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc), .BranchE(BranchE),
        .ITE(ITE), .ITFirstCondE(ITFirstCondE), .ITMaskE(ITMaskE), .TidD(TidD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .BranchTakenE(BranchTakenE), .CondExE(CondExE), .UndefE(UndefE),
        .FlagsE(FlagsE), .FlagsD(FlagsD), .ITActiveD(ITActiveD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidE = 0; StallE = 0; FlushE = 0; TidE = 0; CondE = 4'b1110;
        FlagWriteE = 0; ALUFlags = 0; RegWrite = 0; MemWrite = 0; PCSrc = 0;
        BranchE = 0; ITE = 0; ITFirstCondE = 0; ITMaskE = 0;
        #2;
    endtask

    task automatic setv(input logic [TW-1:0] tid, input logic [3:0] cond,
                        input logic [1:0] fw, input logic [3:0] alu);
        ValidE = 1; StallE = 0; FlushE = 0; TidE = tid; CondE = cond;
        FlagWriteE = fw; ALUFlags = alu; RegWrite = 1; MemWrite = 1; PCSrc = 1;
        BranchE = 1; ITE = 0; ITFirstCondE = 0; ITMaskE = 0;
        #2;
    endtask

    task automatic setit(input logic [TW-1:0] tid, input logic [3:0] first, input logic [3:0] mask);
        setv(tid, 4'b1110, 2'b00, 4'b0000);
        ITE = 1; ITFirstCondE = first; ITMaskE = mask;
        #1;
    endtask

    // Thread-1 flags are 1001 (N=1,V=1,Z=0,C=0) when this table is applied.
    logic [3:0] ctab_cond [8] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101,
                                  4'b0100, 4'b0111, 4'b1000, 4'b1001};
    logic       ctab_exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1; TidD = 0;
        setv(0, 4'b1110, 2'b11, 4'b1111);
        chk("rst_condex", 8'(CondExE), 8'd0);
        chk("rst_regwr", 8'(RegWriteE), 8'd0);
        tick(); tick();
        reset = 0;
        idle();
        chk("post_rst_flagsE", 8'(FlagsE), 8'h0);
        chk("post_rst_itact", 8'(ITActiveD), 8'd0);

        // EQ with Z=0 fails, then CMP-like write, then EQ passes.
        setv(0, 4'b0000, 2'b00, 4'b0000);
        chk("eq_z0_condex", 8'(CondExE), 8'd0);
        chk("eq_z0_regwr", 8'(RegWriteE), 8'd0);
        tick();
        setv(0, 4'b1110, 2'b11, 4'b0100);
        chk("cmp_condex", 8'(CondExE), 8'd1);
        chk("cmp_flagsE_nobyp", 8'(FlagsE), 8'h0);
        chk("cmp_flagsD_byp", 8'(FlagsD), 8'h4);
        tick();
        setv(0, 4'b0000, 2'b00, 4'b0000);
        chk("eq_flagsE", 8'(FlagsE), 8'h4);
        chk("eq_regwr", 8'(RegWriteE), 8'd1);
        chk("eq_memwr", 8'(MemWriteE), 8'd1);
        chk("eq_pcsrc", 8'(PCSrcE), 8'd1);
        chk("eq_branch", 8'(BranchTakenE), 8'd1);
        tick();

        // Thread isolation and bypass.
        setv(1, 4'b1110, 2'b11, 4'b1001);
        TidD = 0; #1;
        chk("iso_t0_flagsD", 8'(FlagsD), 8'h4);
        TidD = 1; #1;
        chk("iso_t1_byp", 8'(FlagsD), 8'h9);
        tick();
        idle(); TidE = 1; #1;
        chk("iso_t1_flagsE", 8'(FlagsE), 8'h9);

        for (int i = 0; i < 8; i++) begin
            setv(1, ctab_cond[i], 2'b00, 4'b0000);
            chk($sformatf("cond_%b", ctab_cond[i]), 8'(CondExE), 8'(ctab_exp[i]));
            tick();
        end

        // ITT EQ with Z=1 on thread 0, with a stall inside the block.
        TidD = 0;
        setit(0, 4'b0000, 4'b0100);
        chk("it_condex", 8'(CondExE), 8'd1);
        chk("it_active_byp", 8'(ITActiveD), 8'd1);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("itA_regwr", 8'(RegWriteE), 8'd1);
        chk("itA_active", 8'(ITActiveD), 8'd1);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000); StallE = 1; #1;
        chk("stall_memwr", 8'(MemWriteE), 8'd0);
        chk("stall_active", 8'(ITActiveD), 8'd1);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("itB_condex", 8'(CondExE), 8'd1);
        chk("itB_active_drop", 8'(ITActiveD), 8'd0);
        tick();
        idle();
        chk("it_done", 8'(ITActiveD), 8'd0);

        // Same block with Z=0: both gated off, state still advances.
        setv(0, 4'b1110, 2'b10, 4'b0000);
        tick();
        setit(0, 4'b0000, 4'b0100);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("itz0A_condex", 8'(CondExE), 8'd0);
        chk("itz0A_regwr", 8'(RegWriteE), 8'd0);
        chk("itz0A_active", 8'(ITActiveD), 8'd1);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("itz0B_condex", 8'(CondExE), 8'd0);
        chk("itz0B_active", 8'(ITActiveD), 8'd0);
        tick();
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("after_it_al", 8'(CondExE), 8'd1);
        tick();

        // Flush blocks flag writes.
        setv(0, 4'b1110, 2'b11, 4'b1111); FlushE = 1; #1;
        chk("flush_condex", 8'(CondExE), 8'd0);
        chk("flush_regwr", 8'(RegWriteE), 8'd0);
        tick();
        idle();
        chk("flush_flags", 8'(FlagsE), 8'h0);

        // Undefined condition, failed-condition write, partial write.
        setv(0, 4'b1111, 2'b00, 4'b0000);
        chk("undef", 8'(UndefE), 8'd1);
        chk("undef_condex", 8'(CondExE), 8'd0);
        tick();
        setv(0, 4'b0000, 2'b10, 4'b1111);
        chk("nz_fail_condex", 8'(CondExE), 8'd0);
        tick();
        idle();
        chk("nz_fail_flags", 8'(FlagsE), 8'h0);
        setv(0, 4'b1110, 2'b01, 4'b1111);
        tick();
        idle();
        chk("cv_partial", 8'(FlagsE), 8'h3);

        // Reset in the middle of an IT block.
        setit(0, 4'b0000, 4'b0010);
        tick();
        idle();
        chk("mid_it_active", 8'(ITActiveD), 8'd1);
        reset = 1;
        tick();
        reset = 0;
        idle();
        chk("rst_it_clear", 8'(ITActiveD), 8'd0);
        chk("rst_flagsD_t0", 8'(FlagsD), 8'h0);
        TidD = 1; #1;
        chk("rst_flagsD_t1", 8'(FlagsD), 8'h0);
        setv(0, 4'b1110, 2'b00, 4'b0000);
        chk("rst_al_regwr", 8'(RegWriteE), 8'd1);
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
